// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle MIPS-style datapath
//
// Ports:
//   clock, reset          single clock; asynchronous active-high reset
//   opcode[5:0]           instruction bits [31:26] from the instruction register
//   zero                  ALU zero flag (branch decision)
//   mem_ready             memory handshake; an access completes in a cycle where it is 1
//   pc_write .. alu_src_a 1-bit datapath enables/selects
//   alu_src_b .. mem_to_reg 2-bit datapath selects
//   state[3:0]            current state code (debug)
//   instr_count           retired-instruction counter, wraps at all-ones
module multicycle_control #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic [1:0]             reg_dst,
    output logic [1:0]             mem_to_reg,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        RTEXEC   = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Plain 4-bit register so the unused codes 13-15 remain representable
    // and are recovered through the default branch.
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       retire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = FETCH;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR load and PC+4 only when the instruction word actually arrives
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTEXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_d = MEMWRITE;
                end
            end
            MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
            end
            MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
                state_d   = mem_ready ? FETCH : MEMWRITE;
            end
            RTEXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                retire     = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg;
    logic [3:0] state;
    logic [3:0] instr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multicycle_control #(.COUNT_WIDTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .instr_count(instr_count)
    );

    // {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a,
    //  alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg}
    logic [16:0] act_outs;
    assign act_outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a,
                       alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg};

    typedef struct {
        logic [3:0]  st;
        logic [16:0] outs;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   exp_count = 0;

    // Hand-written output table for each state.
    function automatic logic [16:0] exp_out(input int st, input logic mr, input logic z);
        logic pw, iw, iod, mrd, mwr, rw, sa;
        logic [1:0] sb_, op, ps, rd, m2r;
        pw = 0; iw = 0; iod = 0; mrd = 0; mwr = 0; rw = 0; sa = 0;
        sb_ = 2'b00; op = 2'b00; ps = 2'b00; rd = 2'b00; m2r = 2'b00;
        case (st)
            0:  begin mrd = 1; sb_ = 2'b01; pw = mr; iw = mr; end
            1:  begin sb_ = 2'b11; end
            2:  begin sa = 1; sb_ = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 2'b01; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 2'b01; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pw = z; end
            9:  begin sa = 1; sb_ = 2'b10; end
            10: begin rw = 1; end
            11: begin pw = 1; ps = 2'b10; end
            12: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
            default: ;
        endcase
        return {pw, iw, iod, mrd, mwr, rw, sa, sb_, op, ps, rd, m2r};
    endfunction

    // One cycle of stimulus: drive inputs, queue the expected response,
    // advance to just after the next rising edge.
    task automatic step(input int st, input logic mr, input logic z);
        exp_t e;
        mem_ready = mr;
        zero      = z;
        e.st   = 4'(st);
        e.outs = exp_out(st, mr, z);
        e.cnt  = 4'(exp_count);
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic retire();
        exp_count = (exp_count + 1) % 16;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        opcode = op;
        for (int i = 0; i < fw; i++) step(0, 1'b0, z);
        step(0, 1'b1, z);
        step(1, 1'b1, z);
        case (op)
            6'b000000: begin step(6, 1, z); step(7, 1, z); retire(); end
            6'b100011: begin
                step(2, 1, z);
                for (int i = 0; i < mw; i++) step(3, 1'b0, z);
                step(3, 1, z); step(4, 1, z); retire();
            end
            6'b101011: begin
                step(2, 1, z);
                for (int i = 0; i < mw; i++) step(5, 1'b0, z);
                step(5, 1, z); retire();
            end
            6'b000100: begin step(8, 1, z); retire(); end
            6'b001000: begin step(9, 1, z); step(10, 1, z); retire(); end
            6'b000010: begin step(11, 1, z); retire(); end
            6'b000011: begin step(12, 1, z); retire(); end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from state updates.
    always @(negedge clock) begin
        exp_t e;
        check("no_read_write_overlap", int'(mem_read & mem_write), 0);
        check("no_regw_memw_overlap", int'(reg_write & mem_write), 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", int'(state), int'(e.st));
            check("outputs", int'(act_outs), int'(e.outs));
            check("instr_count", int'(instr_count), int'(e.cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #3;
        check("reset_state", int'(state), 0);
        check("reset_count", int'(instr_count), 0);
        check("reset_outputs", int'(act_outs), int'(exp_out(0, 1'b0, 1'b0)));
        @(posedge clock);
        #1;
        reset = 1'b0;

        do_instr(6'b000000, 1'b0, 0, 0);   // R-type
        do_instr(6'b100011, 1'b0, 0, 2);   // lw, two wait cycles in MEMREAD
        do_instr(6'b101011, 1'b0, 0, 1);   // sw, one wait cycle in MEMWRITE
        do_instr(6'b000100, 1'b1, 0, 0);   // beq taken
        do_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
        do_instr(6'b001000, 1'b0, 1, 0);   // addi, one fetch wait cycle
        do_instr(6'b000011, 1'b0, 0, 0);   // jal
        do_instr(6'b111111, 1'b0, 0, 0);   // illegal opcode
        check("count_after_mix", int'(instr_count), 7);

        // sw abandoned by an asynchronous reset while waiting in MEMWRITE
        opcode = 6'b101011;
        step(0, 1, 0);
        step(1, 1, 0);
        step(2, 1, 0);
        mem_ready = 1'b0;
        #2;
        check("pre_reset_state", int'(state), 5);
        reset = 1'b1;
        #1;
        check("async_reset_state", int'(state), 0);
        check("async_reset_mem_write", int'(mem_write), 0);
        check("async_reset_count", int'(instr_count), 0);
        reset = 1'b0;
        exp_count = 0;
        @(posedge clock);
        #1;
        check("post_reset_fetch_hold", int'(state), 0);

        // 15 jumps reach all-ones, the 16th wraps to zero
        for (int k = 0; k < 15; k++) do_instr(6'b000010, 1'b0, 0, 0);
        check("count_all_ones", int'(instr_count), 15);
        do_instr(6'b000010, 1'b0, 0, 0);
        check("count_wrap", int'(instr_count), 0);

        @(negedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
